// File: rtl/branch_ctrl.sv
// Branch controller: bimodal branch predictor with a two-state resolution FSM.
// A table of 2-bit saturating counters is indexed by pc_IF[PHT_IDX_W+1:2].
// The IF branch is predicted combinationally. A branch accepted in IF waits in
// PEND until it is resolved in ID. A mispredict flushes IF in the same cycle.
// Optional feature: define BRCTRL_STATS_EN to build the branch/miss statistics
// counters. Without it, branch_cnt and miss_cnt are tied to zero.
module branch_ctrl #(
  parameter int PHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_IF,
  input  logic [31:0] pc_IF,
  input  logic        branch_ID,
  input  logic        jump_or_not,
  input  logic        stall,
  output logic        predict_jump,
  output logic        flush_IF,
  output logic        correct,
  output logic [15:0] branch_cnt,
  output logic [15:0] miss_cnt
);

  localparam int PHT_DEPTH = 1 << PHT_IDX_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             pht_q [PHT_DEPTH];
  logic [PHT_IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic                   pend_pred_q, pend_pred_d;

  logic [PHT_IDX_W-1:0]   idx_s;
  logic                   pred_s;
  logic                   resolve_s;
  logic                   mispredict_s;
  logic                   accept_s;
  logic                   unused_pc_s;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == 2'b11) res = cnt;
      else              res = cnt + 2'b01;
    end else begin
      if (cnt == 2'b00) res = cnt;
      else              res = cnt - 2'b01;
    end
    return res;
  endfunction

  assign idx_s       = pc_IF[PHT_IDX_W+1:2];
  assign unused_pc_s = ^{pc_IF[31:PHT_IDX_W+2], pc_IF[1:0]};

  // Prediction, resolution detection and next-state selection.
  always_comb begin
    state_d      = state_q;
    pend_idx_d   = pend_idx_q;
    pend_pred_d  = pend_pred_q;
    pred_s       = 1'b0;
    resolve_s    = 1'b0;
    mispredict_s = 1'b0;
    accept_s     = 1'b0;

    // The table read is the pre-update value, so a same-cycle update to the
    // same entry does not affect this prediction.
    if (branch_IF) pred_s = pht_q[idx_s][1];
    else           pred_s = 1'b0;

    if (!stall && (state_q == PEND) && branch_ID) begin
      resolve_s    = 1'b1;
      mispredict_s = (pend_pred_q != jump_or_not);
    end else begin
      resolve_s    = 1'b0;
      mispredict_s = 1'b0;
    end

    // On a mispredict the IF instruction is on the wrong path, so it is dropped.
    accept_s = branch_IF && !stall && !mispredict_s;

    case (state_q)
      IDLE: begin
        if (accept_s) state_d = PEND;
        else          state_d = IDLE;
      end
      PEND: begin
        if (mispredict_s)   state_d = IDLE;
        else if (accept_s)  state_d = PEND;
        else if (resolve_s) state_d = IDLE;
        else                state_d = PEND;
      end
      default: state_d = IDLE;
    endcase

    if (accept_s) begin
      pend_idx_d  = idx_s;
      pend_pred_d = pred_s;
    end else begin
      pend_idx_d  = pend_idx_q;
      pend_pred_d = pend_pred_q;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  assign predict_jump = rst_n & pred_s;
  assign flush_IF     = rst_n & mispredict_s;
  assign correct      = ~flush_IF;

  // FSM state and pending-branch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_idx_q  <= {PHT_IDX_W{1'b0}};
      pend_pred_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_idx_q  <= pend_idx_d;
      pend_pred_q <= pend_pred_d;
    end
  end

  // Pattern history table: all entries start weakly taken, trained on resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= 2'b10;
      end
    end else if (resolve_s) begin
      pht_q[pend_idx_q] <= sat_update(pht_q[pend_idx_q], jump_or_not);
    end
  end

`ifdef BRCTRL_STATS_EN
  logic [15:0] branch_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating counts of resolved branches and of mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= 16'h0000;
      miss_cnt_q   <= 16'h0000;
    end else begin
      if (resolve_s && (branch_cnt_q != 16'hFFFF)) branch_cnt_q <= branch_cnt_q + 16'h0001;
      if (mispredict_s && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'h0001;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;
`else
  assign branch_cnt = 16'h0000;
  assign miss_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed scoreboard bench for branch_ctrl. Each stimulus cycle pushes its
// hand-computed expectation. A negedge monitor pops it and compares the outputs.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_IF = 1'b0;
  logic [31:0] pc_IF = 32'h0;
  logic        branch_ID = 1'b0;
  logic        jump_or_not = 1'b0;
  logic        stall = 1'b0;
  logic        predict_jump;
  logic        flush_IF;
  logic        correct;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  branch_ctrl #(.PHT_IDX_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .branch_IF   (branch_IF),
    .pc_IF       (pc_IF),
    .branch_ID   (branch_ID),
    .jump_or_not (jump_or_not),
    .stall       (stall),
    .predict_jump(predict_jump),
    .flush_IF    (flush_IF),
    .correct     (correct),
    .branch_cnt  (branch_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pj;
    logic        fl;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] m_bc = 16'h0;
  logic [15:0] m_mc = 16'h0;

  function automatic void chk(input string nm, input string fld,
                              input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
  endfunction

  // Monitor: compare outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk(mon_e.name, "predict_jump", {15'b0, predict_jump}, {15'b0, mon_e.pj});
      chk(mon_e.name, "flush_IF",     {15'b0, flush_IF},     {15'b0, mon_e.fl});
      chk(mon_e.name, "correct",      {15'b0, correct},      {15'b0, ~mon_e.fl});
      chk(mon_e.name, "branch_cnt",   branch_cnt,            mon_e.bc);
      chk(mon_e.name, "miss_cnt",     miss_cnt,              mon_e.mc);
    end
  end

  function automatic void push_exp(input string nm, input logic pj, input logic fl);
    exp_t e;
    e.name = nm;
    e.pj   = pj;
    e.fl   = fl;
`ifdef BRCTRL_STATS_EN
    e.bc   = m_bc;
    e.mc   = m_mc;
`else
    e.bc   = 16'h0000;
    e.mc   = 16'h0000;
`endif
    sb_q.push_back(e);
  endfunction

  // One cycle of stimulus with its expected prediction/flush and whether it resolves.
  task automatic step(input logic bif, input logic [31:0] pc, input logic bid,
                      input logic jon, input logic stl, input logic e_pj,
                      input logic e_fl, input logic e_res, input string nm);
    @(posedge clk);
    #1;
    branch_IF   = bif;
    pc_IF       = pc;
    branch_ID   = bid;
    jump_or_not = jon;
    stall       = stl;
    push_exp(nm, e_pj, e_fl);
    if (e_res && m_bc != 16'hFFFF) m_bc = m_bc + 16'h0001;
    if (e_fl && m_mc != 16'hFFFF)  m_mc = m_mc + 16'h0001;
  endtask

  // Pull reset low just after an edge, check before the next edge, then release.
  task automatic rst_step(input string nm);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    branch_IF   = 1'b1;
    pc_IF       = 32'h10;
    branch_ID   = 1'b1;
    jump_or_not = 1'b0;
    stall       = 1'b0;
    m_bc        = 16'h0;
    m_mc        = 16'h0;
    push_exp(nm, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    branch_IF = 1'b0;
    branch_ID = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_step("rst_init");
    // Weakly-taken reset value predicts taken, then a not-taken resolution mispredicts.
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pred_pc10");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "miss_pc10");
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pred_pc10_wnt");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ok_pc10_nt");
    // Four not-taken resolutions on pc 0x20 saturate at 00.
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "p20_1");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "r20_1");
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p20_2");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "r20_2");
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p20_3");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "r20_3");
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p20_4");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "r20_4");
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p20_5_no_underflow");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "r20_5");
    // Back-to-back branches on pc 0x30; second stays pending.
    step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "b2b_first");
    step(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "b2b_second");
    step(1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_resolve");
    // Read-before-write where the update flips the prediction bit (01 -> 10).
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rbw_p1");
    step(1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "rbw_r1");
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rbw_p2");
    step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "rbw_flip_old_val");
    // IDLE ignores branch_ID; also proves the wrong-path IF branch was dropped.
    step(1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_ignore_id");
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pred_pc10_after_flip");
    // Stall holds a pending mispredict for three cycles.
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "stall_1");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "stall_2");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "stall_3");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "stall_release");
    // Asynchronous reset while a branch is pending.
    step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pend_before_rst");
    rst_step("rst_mid_pend");
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst_pc10");
    step(1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst_ok");
    step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst_pc30");
    step(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst_miss");
    step(1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "final_idle");

    for (int k = 0; k < 5 && sb_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
